axi_inf_write_state_core: RTL and testbench

AXI_INF_WRITE_STATE_CORE -- requirements
Module: axi_inf_write_state_core

---
 rtl/axi_inf_write_state_core.sv | 169 ++++++++++++++++
 tb/tb_axi_inf_write_state_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_inf_write_state_core.sv
// axi_inf_write_state_core
// Single-burst AXI write master: takes one burst request at a time, issues the
// AW beat, streams W beats straight out of a first-word-fall-through FIFO and
// waits for the B response before accepting the next request.
// Optional feature macro: WRITE_RESP_CHECK_EN -- when defined, a non-OKAY
// write response sets the sticky resp_err flag; when undefined resp_err is 0.
module axi_inf_write_state_core #(
  parameter int IDSIZE = 3,
  parameter int ID     = 0,
  parameter int LSIZE  = 9,
  parameter int ASIZE  = 29,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic                 write_req,
  input  logic [LSIZE-1:0]     req_len,
  input  logic [ASIZE-1:0]     req_addr,
  output logic                 req_resp,
  output logic                 req_done,
  input  logic [DSIZE-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 pull_data_en,
  output logic [IDSIZE-1:0]    axi_awid,
  output logic [ASIZE-1:0]     axi_awaddr,
  output logic [LSIZE-1:0]     axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awlock,
  output logic [3:0]           axi_awcache,
  output logic [2:0]           axi_awprot,
  output logic [3:0]           axi_awqos,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [DSIZE-1:0]     axi_wdata,
  output logic [DSIZE/8-1:0]   axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [IDSIZE-1:0]    axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,
  output logic                 resp_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Beat size in bytes as log2, e.g. 5 for a 256-bit bus.
  localparam logic [2:0]       AW_SIZE = 3'($clog2(DSIZE/8));
  localparam logic [LSIZE-1:0] LEN_ONE = {{(LSIZE-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [ASIZE-1:0] addr_r;
  logic [LSIZE-1:0] awlen_r;
  logic [LSIZE-1:0] beat_r;
  logic             req_resp_r;
  logic             req_done_r;
  logic             resp_err_r;

  logic accept_s;
  logic addr_s;
  logic data_s;
  logic last_s;
  logic w_hs_s;
  logic unused_s;

  assign accept_s = (state_r == ST_IDLE) && write_req && (req_len != {LSIZE{1'b0}});
  assign addr_s   = (state_r == ST_ADDR);
  assign data_s   = (state_r == ST_DATA);
  assign last_s   = (beat_r == awlen_r);
  assign w_hs_s   = data_s && in_valid && axi_wready;

  // Burst sequencing: accept a request, walk AW -> W -> B, emit the handshake pulses
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ASIZE{1'b0}};
      awlen_r    <= {LSIZE{1'b0}};
      beat_r     <= {LSIZE{1'b0}};
      req_resp_r <= 1'b0;
      req_done_r <= 1'b0;
    end else begin
      req_resp_r <= 1'b0;
      req_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r     <= req_addr;
            awlen_r    <= req_len - LEN_ONE;
            beat_r     <= {LSIZE{1'b0}};
            req_resp_r <= 1'b1;
            state_r    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi_awready) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs_s) begin
            if (last_s) begin
              beat_r  <= {LSIZE{1'b0}};
              state_r <= ST_RESP;
            end else begin
              beat_r <= beat_r + LEN_ONE;
            end
          end
        end
        ST_RESP: begin
          if (axi_bvalid) begin
            req_done_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WRITE_RESP_CHECK_EN
  // Sticky error flag: any non-OKAY write response is remembered until reset
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      resp_err_r <= 1'b0;
    end else if (axi_bvalid && axi_bready && (axi_bresp != 2'b00)) begin
      resp_err_r <= 1'b1;
    end else begin
      resp_err_r <= resp_err_r;
    end
  end
  assign unused_s = ^axi_bid;
`else
  assign resp_err_r = 1'b0;
  assign unused_s   = ^{axi_bid, axi_bresp};
`endif

  // AW channel: payload comes from the latched request, constants only while offered
  assign axi_awvalid = addr_s;
  assign axi_awaddr  = addr_r;
  assign axi_awlen   = awlen_r;
  assign axi_awid    = addr_s ? IDSIZE'(ID) : {IDSIZE{1'b0}};
  assign axi_awsize  = addr_s ? AW_SIZE : 3'b000;
  assign axi_awburst = addr_s ? 2'b01 : 2'b00;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = addr_s ? 4'b0011 : 4'b0000;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;

  // W channel: the FIFO head is presented directly; its valid gates wvalid
  assign axi_wvalid   = data_s && in_valid;
  assign axi_wdata    = data_s ? in_data : {DSIZE{1'b0}};
  assign axi_wstrb    = data_s ? {(DSIZE/8){1'b1}} : {(DSIZE/8){1'b0}};
  assign axi_wlast    = data_s && last_s;
  assign pull_data_en = axi_wvalid && axi_wready;

  // B channel and requester handshakes
  assign axi_bready = (state_r == ST_RESP);
  assign req_resp   = req_resp_r;
  assign req_done   = req_done_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_axi_inf_write_state_core.sv
// Self-checking bench for axi_inf_write_state_core (default parameters).
// Expected AW payloads and W beats are queued when a burst is requested and
// popped by a negedge monitor as the DUT completes each handshake.
module tb_axi_inf_write_state_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_req;
  logic [8:0]   req_len;
  logic [28:0]  req_addr;
  logic         req_resp, req_done;
  logic [255:0] in_data;
  logic         in_valid;
  logic         pull_data_en;
  logic [2:0]   axi_awid;
  logic [28:0]  axi_awaddr;
  logic [8:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awlock;
  logic [3:0]   axi_awcache;
  logic [2:0]   axi_awprot;
  logic [3:0]   axi_awqos;
  logic         axi_awvalid, axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast, axi_wvalid, axi_wready;
  logic [2:0]   axi_bid;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid, axi_bready;
  logic         resp_err;

  axi_inf_write_state_core dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .write_req(write_req), .req_len(req_len), .req_addr(req_addr),
    .req_resp(req_resp), .req_done(req_done),
    .in_data(in_data), .in_valid(in_valid), .pull_data_en(pull_data_en),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [28:0] addr; logic [8:0] len; } aw_t;
  typedef struct { logic [255:0] data; logic last; } w_t;
  aw_t aw_q[$];
  w_t  w_q[$];

  int checks = 0;
  int errors = 0;
  int word_idx = 0;   // words consumed from the modelled FIFO
  int exp_word = 0;   // next word index to be queued as expected
  int pull_cnt = 0, last_cnt = 0, resp_cnt = 0, done_cnt = 0;
  bit aw_pending = 1'b0;
  logic exp_err = 1'b0;

  function automatic logic [255:0] pat(input int idx);
    return {8{32'hA500_0000 ^ 32'(idx)}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge
  initial begin
    aw_t a;
    w_t  w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!in_valid) check("wvalid_no_data", axi_wvalid, 1'b0);
        check("pull_en", pull_data_en, axi_wvalid && axi_wready);
        if (aw_pending) check("w_before_aw", axi_wvalid, 1'b0);
        if (axi_awvalid && aw_q.size() > 0) check("aw_stable", axi_awaddr, aw_q[0].addr);
        if (axi_awvalid && axi_awready) begin
          check("aw_expected", aw_q.size() > 0, 1'b1);
          if (aw_q.size() > 0) begin
            a = aw_q.pop_front();
            check("awaddr", axi_awaddr, a.addr);
            check("awlen", axi_awlen, a.len);
            check("awsize", axi_awsize, 3'd5);
            check("awburst", axi_awburst, 2'b01);
            check("awcache", axi_awcache, 4'b0011);
            check("aw_misc", {axi_awid, axi_awlock, axi_awprot, axi_awqos}, 11'd0);
          end
          aw_pending = 1'b0;
        end
        if (pull_data_en) begin
          pull_cnt++;
          check("w_expected", w_q.size() > 0, 1'b1);
          if (w_q.size() > 0) begin
            w = w_q.pop_front();
            check("wdata", axi_wdata, w.data);
            check("wlast", axi_wlast, w.last);
            check("wstrb", axi_wstrb, 32'hFFFF_FFFF);
          end
          if (axi_wlast) last_cnt++;
          word_idx++;
          in_data = pat(word_idx);
        end
        if (req_resp) resp_cnt++;
        if (req_done) begin
          done_cnt++;
          check("resp_err_at_done", resp_err, exp_err);
        end
      end
    end
  end

  // Queue expectations for one burst
  task automatic queue_burst(input int len, input logic [28:0] addr);
    aw_t a;
    w_t  w;
    a.addr = addr;
    a.len  = 9'(len - 1);
    aw_q.push_back(a);
    for (int i = 0; i < len; i++) begin
      w.data = pat(exp_word + i);
      w.last = (i == len - 1);
      w_q.push_back(w);
    end
    exp_word += len;
    aw_pending = 1'b1;
  endtask

  // One burst; mode 1 toggles wready and drops in_valid for cycles 10..20
  task automatic burst(input int len, input logic [28:0] addr, input int mode, input int aw_dly);
    int d0, p0, l0, r0, awc;
    bit got;
    d0 = done_cnt; p0 = pull_cnt; l0 = last_cnt; r0 = resp_cnt; awc = 0; got = 1'b0;
    queue_burst(len, addr);
    @(posedge clk); #1;
    write_req = 1'b1; req_len = 9'(len); req_addr = addr; axi_awready = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (req_resp) write_req = 1'b0;
      if (axi_awvalid) awc++;
      axi_awready = (awc > aw_dly);
      if (mode == 1) begin
        axi_wready = c[0];
        in_valid   = !(c >= 10 && c <= 20);
      end
      if (req_done) got = 1'b1;
    end
    write_req = 1'b0; axi_wready = 1'b1; in_valid = 1'b1; axi_awready = 1'b0;
    @(negedge clk); #1;
    check("done_count", done_cnt - d0, 1);
    check("pull_count", pull_cnt - p0, len);
    check("wlast_count", last_cnt - l0, 1);
    check("req_resp_count", resp_cnt - r0, 1);
    check("awvalid_cycles", awc, aw_dly + 1);
    check("w_queue_left", w_q.size(), 0);
  endtask

  initial begin
    int d0, p0, r0;
    rst_n = 1'b0; write_req = 1'b0; req_len = 9'd0; req_addr = 29'd0;
    in_data = pat(0); in_valid = 1'b1;
    axi_awready = 1'b0; axi_wready = 1'b1;
    axi_bid = 3'd5; axi_bresp = 2'b00; axi_bvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, req_resp, req_done, pull_data_en, resp_err}, 8'd0);
    check("rst_payload", {axi_awaddr, axi_awlen}, 38'd0);
    rst_n = 1'b1;

    burst(4, 29'h1000, 0, 0);
    burst(1, 29'h2000, 0, 0);
    burst(256, 29'h3000, 1, 0);
    burst(3, 29'h4000, 0, 5);

    // Zero-length request must be ignored
    r0 = resp_cnt;
    @(posedge clk); #1;
    write_req = 1'b1; req_len = 9'd0; req_addr = 29'h5000;
    repeat (5) @(posedge clk);
    #1;
    check("len0_awvalid", axi_awvalid, 1'b0);
    write_req = 1'b0;
    @(negedge clk); #1;
    check("len0_req_resp", resp_cnt - r0, 0);

    // Reset in the middle of an 8-beat burst
    d0 = done_cnt; p0 = pull_cnt;
    queue_burst(8, 29'h7000);
    @(posedge clk); #1;
    write_req = 1'b1; req_len = 9'd8; req_addr = 29'h7000; axi_awready = 1'b1;
    for (int c = 0; c < 200 && (pull_cnt - p0) < 2; c++) begin
      @(posedge clk); #1;
      if (req_resp) write_req = 1'b0;
    end
    write_req = 1'b0; axi_awready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, req_resp, req_done, pull_data_en, resp_err}, 8'd0);
    check("midrst_payload", {axi_awaddr, axi_awlen, axi_wdata[31:0]}, 70'd0);
    aw_q.delete(); w_q.delete(); aw_pending = 1'b0; exp_word = word_idx;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_no_done", done_cnt - d0, 0);
    burst(2, 29'h5000, 0, 0);

    // Error response
    axi_bresp = 2'b10;
`ifdef WRITE_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    burst(2, 29'h6000, 0, 0);
    axi_bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("resp_err_sticky", resp_err, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
